// File: rtl/mix_column_engine.sv
// Iterative AES MixColumns / InvMixColumns engine.
// Accepts a 128-bit state, transforms COLS_PER_CYCLE columns per clock and
// returns the result over a valid/ready handshake. The mode is chosen per state.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake
//   in_state, in_inverse   state to transform (column j = [32j+31:32j], b0 = MSB)
//                          and mode (0 = MixColumns, 1 = InvMixColumns)
//   out_valid / out_ready  output handshake
//   out_state              transformed state, same layout as in_state
//   busy                   high while a state is held (BUSY or DONE)
module mix_column_engine #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned CPC_SAFE  = (COLS_PER_CYCLE == 0) ? 1 : COLS_PER_CYCLE;
    localparam int unsigned NUM_STEPS = 4 / CPC_SAFE;
    localparam int unsigned STEP_W    = 2;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
        $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // GF(2^8) multiply by 2 modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns on one column, b0 in the top byte
    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3, t;
        b0 = c[31:24];
        b1 = c[23:16];
        b2 = c[15:8];
        b3 = c[7:0];
        t  = b0 ^ b1 ^ b2 ^ b3;
        return {b0 ^ t ^ xtime(b0 ^ b1),
                b1 ^ t ^ xtime(b1 ^ b2),
                b2 ^ t ^ xtime(b2 ^ b3),
                b3 ^ t ^ xtime(b3 ^ b0)};
    endfunction

    // Inverse = forward applied after a {5,0,4,0} pre-mix
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] u, v;
        logic [31:0] pre;
        u   = xtime(xtime(c[31:24] ^ c[15:8]));
        v   = xtime(xtime(c[23:16] ^ c[7:0]));
        pre = inv ? (c ^ {u, v, u, v}) : c;
        return mix_fwd(pre);
    endfunction

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [127:0]      work_q, work_d;
    logic              mode_q, mode_d;
    logic              in_ready_q, out_valid_q, busy_q;

    logic [1:0]        col_idx [CPC_SAFE];
    logic [31:0]       col_res [CPC_SAFE];

    // Column mux: step k works on columns k*C .. k*C+C-1
    for (genvar i = 0; i < int'(CPC_SAFE); i++) begin : g_col
        assign col_idx[i] = 2'((32'(step_q) * CPC_SAFE) + 32'(i));
        assign col_res[i] = mix_col(work_q[{col_idx[i], 5'b0} +: 32], mode_q);
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        work_d  = work_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                // in_ready_q is low in the first clock after reset release
                if (in_valid && in_ready_q) begin
                    work_d  = in_state;
                    mode_d  = in_inverse;
                    step_d  = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int i = 0; i < int'(CPC_SAFE); i++) begin
                    work_d[{col_idx[i], 5'b0} +: 32] = col_res[i];
                end
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            work_q      <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            work_q      <= work_d;
            mode_q      <= mode_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = work_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mix_column_engine.sv
// Scoreboard bench for mix_column_engine: three instances (C = 1, 2, 4)
// exercised one after another; expected results are queued at issue and
// checked by a monitor whenever an output handshake occurs.
module tb_mix_column_engine;

    localparam int NI = 3;

    localparam logic [127:0] V_IN    = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] V_OUT   = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] FP_IN   = 128'hc6c6c6c6_01010101_d4d4d4d5_c6c6c6c6;
    localparam logic [127:0] FP_FWD  = 128'hc6c6c6c6_01010101_d5d5d7d6_c6c6c6c6;
    localparam logic [127:0] FP_FIX  = 128'h01010101_c6c6c6c6_01010101_c6c6c6c6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid   [NI];
    logic         in_ready   [NI];
    logic [127:0] in_state   [NI];
    logic         in_inverse [NI];
    logic         out_valid  [NI];
    logic         out_ready  [NI];
    logic [127:0] out_state  [NI];
    logic         busy       [NI];

    int           rdy_mode [NI];   // 0: hold low, 1: hold high, 2: random
    logic [127:0] exp_q [NI][$];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mix_column_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_inverse(in_inverse[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: generic GF(2^8) matrix multiply
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s, input logic inv);
        logic [7:0]   m [4];
        logic [7:0]   b [4];
        logic [7:0]   r;
        logic [31:0]  col;
        logic [127:0] res;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[32*c +: 32];
            for (int j = 0; j < 4; j++) b[j] = col[31-8*j -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(m[(j - rr) & 3], b[j]);
                res[32*c + 31 - 8*rr -: 8] = r;
            end
        end
        return res;
    endfunction

    // out_ready driver, changes mid-cycle
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NI; i++) begin
            if (rdy_mode[i] == 0)      out_ready[i] = 1'b0;
            else if (rdy_mode[i] == 1) out_ready[i] = 1'b1;
            else                       out_ready[i] = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compare on every output handshake
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst_n && out_valid[i] && out_ready[i]) begin
                if (exp_q[i].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output C=%0d: got %h expected none", 1 << i, out_state[i]);
                end else begin
                    check($sformatf("result C=%0d", 1 << i), out_state[i], exp_q[i].pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge
    task automatic send(input int i, input logic [127:0] s, input logic inv, input logic [127:0] e);
        bit rdy;
        int guard;
        guard = 0;
        in_valid[i]   = 1'b1;
        in_state[i]   = s;
        in_inverse[i] = inv;
        exp_q[i].push_back(e);
        do begin
            @(negedge clk);
            rdy = in_ready[i];
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 200);
        if (!rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout C=%0d: got in_ready=0 expected 1", 1 << i);
        end
        in_valid[i]   = 1'b0;
        in_state[i]   = ~s;
        in_inverse[i] = ~inv;
    endtask

    task automatic drain(input int i);
        int guard;
        guard = 0;
        while (exp_q[i].size() != 0 && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check($sformatf("drain C=%0d", 1 << i), 128'(exp_q[i].size()), 128'(0));
    endtask

    task automatic run_instance(input int i);
        int lat, nsteps, waits;
        logic [127:0] s, f;
        logic inv;
        string tag;
        nsteps = 4 >> i;
        tag = $sformatf("C=%0d", 1 << i);

        // Directed forward, latency and back-pressure
        rdy_mode[i] = 0;
        send(i, V_IN, 1'b0, V_OUT);
        lat = 1;
        while (!out_valid[i] && lat < 50) begin
            check({"in_ready_busy ", tag}, 128'(in_ready[i]), 128'(0));
            in_valid[i]   = 1'b1;
            in_state[i]   = {4{$urandom()}};
            in_inverse[i] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
        end
        check({"latency ", tag}, 128'(lat), 128'(nsteps + 1));
        check({"busy_done ", tag}, 128'(busy[i]), 128'(1));
        for (int k = 0; k < 10; k++) begin
            in_valid[i]   = 1'($urandom_range(0, 1));
            in_state[i]   = {4{$urandom()}};
            in_inverse[i] = 1'($urandom_range(0, 1));
            check({"hold_valid ", tag}, 128'(out_valid[i]), 128'(1));
            check({"hold_state ", tag}, out_state[i], V_OUT);
            check({"in_ready_done ", tag}, 128'(in_ready[i]), 128'(0));
            @(posedge clk);
            #1;
        end
        in_valid[i] = 1'b0;
        rdy_mode[i] = 1;
        @(posedge clk);
        #1;
        check({"valid_after_hs ", tag}, 128'(out_valid[i]), 128'(0));
        check({"in_ready_after_hs ", tag}, 128'(in_ready[i]), 128'(1));
        check({"busy_after_hs ", tag}, 128'(busy[i]), 128'(0));
        check({"consumed_once ", tag}, 128'(exp_q[i].size()), 128'(0));

        // Inverse of the forward result, then fixed points
        send(i, V_OUT, 1'b1, V_IN);
        send(i, FP_IN, 1'b0, FP_FWD);
        send(i, FP_FWD, 1'b1, FP_IN);
        send(i, FP_FIX, 1'b0, FP_FIX);
        send(i, FP_FIX, 1'b1, FP_FIX);
        drain(i);

        // Asynchronous reset mid-transaction
        send(i, V_IN, 1'b0, V_OUT);
        waits = (nsteps >= 3) ? 2 : nsteps - 1;
        repeat (waits) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q[i].delete();
        check({"rst_valid ", tag}, 128'(out_valid[i]), 128'(0));
        check({"rst_state ", tag}, out_state[i], 128'(0));
        check({"rst_in_ready ", tag}, 128'(in_ready[i]), 128'(0));
        check({"rst_busy ", tag}, 128'(busy[i]), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check({"in_ready_post_rst ", tag}, 128'(in_ready[i]), 128'(1));
        send(i, V_IN, 1'b0, V_OUT);
        drain(i);

        // Streaming with random stalls
        rdy_mode[i] = 2;
        for (int n = 0; n < 100; n++) begin
            s   = {$urandom(), $urandom(), $urandom(), $urandom()};
            inv = 1'($urandom_range(0, 1));
            send(i, s, inv, ref_state(s, inv));
            if (n % 10 == 0) begin
                f = ref_state(s, 1'b0);
                send(i, f, 1'b1, s);
            end
        end
        drain(i);
        rdy_mode[i] = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            in_valid[i]   = 1'b0;
            in_state[i]   = '0;
            in_inverse[i] = 1'b0;
            rdy_mode[i]   = 1;
        end
        #1;
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_in_ready C=%0d", 1 << i), 128'(in_ready[i]), 128'(0));
            check($sformatf("reset_out_valid C=%0d", 1 << i), 128'(out_valid[i]), 128'(0));
            check($sformatf("reset_out_state C=%0d", 1 << i), out_state[i], 128'(0));
            check($sformatf("reset_busy C=%0d", 1 << i), 128'(busy[i]), 128'(0));
        end
        #19;
        rst_n = 1'b1;
        #1;
        check("in_ready_before_first_clk", 128'(in_ready[0]), 128'(0));
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("in_ready_first_clk C=%0d", 1 << i), 128'(in_ready[i]), 128'(1));
        end
        for (int i = 0; i < NI; i++) begin
            run_instance(i);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
